// File: rtl/mem_req_ctrl_if.sv
// Host request/response and memory-side signals of mem_req_ctrl.
// The slave modport is the controller's view; master is the host plus memory side.
interface mem_req_ctrl_if #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned QDEPTH     = 4
) ();

    logic                       req_valid;
    logic                       req_ready;
    logic                       req_wr_rd;
    logic [ADDR_WIDTH-1:0]      req_addr;
    logic [WIDTH-1:0]           req_wdata;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic                       rsp_wr_rd;
    logic [WIDTH-1:0]           rsp_rdata;
    logic                       rsp_err;

    logic                       mem_valid;
    logic                       mem_wr_rd;
    logic [ADDR_WIDTH-1:0]      mem_addr;
    logic [WIDTH-1:0]           mem_wdata;
    logic [WIDTH-1:0]           mem_rdata;
    logic                       mem_ready;

    logic [$clog2(QDEPTH):0]    q_count;

    modport slave (
        input  req_valid, req_wr_rd, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_wr_rd, rsp_rdata, rsp_err,
        input  rsp_ready,
        output mem_valid, mem_wr_rd, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output q_count
    );

    modport master (
        output req_valid, req_wr_rd, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_wr_rd, rsp_rdata, rsp_err,
        output rsp_ready,
        input  mem_valid, mem_wr_rd, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  q_count
    );

endinterface

// File: rtl/mem_req_ctrl.sv
// Queued memory request controller: FIFO of host requests feeding a single-outstanding
// memory access FSM with a response timeout.
module mem_req_ctrl #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned QDEPTH     = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input logic            clk,
    input logic            res,
    mem_req_ctrl_if.slave  bus
);

    localparam int unsigned PtrW = $clog2(QDEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned ToW  = $clog2(TIMEOUT + 1);
    localparam int unsigned EntW = 1 + ADDR_WIDTH + WIDTH;

    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 || TIMEOUT < 2 ||
        DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_param
        $error("mem_req_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                 state_q;
    logic [PtrW-1:0]        wr_ptr_q;
    logic [PtrW-1:0]        rd_ptr_q;
    logic [CntW-1:0]        count_q;
    logic [EntW-1:0]        fifo_q [QDEPTH];
    logic [EntW-1:0]        head;
    logic                   push;
    logic                   pop;

    logic [ToW-1:0]         to_cnt_q;
    logic                   mem_valid_q;
    logic                   mem_wr_rd_q;
    logic [ADDR_WIDTH-1:0]  mem_addr_q;
    logic [WIDTH-1:0]       mem_wdata_q;
    logic                   rsp_valid_q;
    logic                   rsp_wr_rd_q;
    logic [WIDTH-1:0]       rsp_rdata_q;
    logic                   rsp_err_q;

    // Ready depends only on occupancy, so a full queue refuses a push even while popping.
    assign bus.req_ready = (count_q < CntW'(QDEPTH));
    assign push          = bus.req_valid && bus.req_ready;
    assign pop           = (state_q == StIdle) && (count_q != '0);
    assign head          = fifo_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {bus.req_wr_rd, bus.req_addr, bus.req_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // The mem_* registers double as the issue registers and keep the last issued request.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= StIdle;
            to_cnt_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_wr_rd_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_wr_rd_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        mem_valid_q <= 1'b1;
                        mem_wr_rd_q <= head[EntW-1];
                        mem_addr_q  <= head[WIDTH +: ADDR_WIDTH];
                        mem_wdata_q <= head[WIDTH-1:0];
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    mem_valid_q <= 1'b0;
                    to_cnt_q    <= '0;
                    state_q     <= StWait;
                end
                StWait: begin
                    if (bus.mem_ready) begin
                        rsp_valid_q <= 1'b1;
                        rsp_wr_rd_q <= mem_wr_rd_q;
                        rsp_rdata_q <= mem_wr_rd_q ? '0 : bus.mem_rdata;
                        rsp_err_q   <= 1'b0;
                        state_q     <= StResp;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                        if (to_cnt_q == ToW'(TIMEOUT - 1)) begin
                            rsp_valid_q <= 1'b1;
                            rsp_wr_rd_q <= mem_wr_rd_q;
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                            state_q     <= StResp;
                        end
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_wr_rd = mem_wr_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_wr_rd = rsp_wr_rd_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.q_count   = count_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl with a one-cycle registered memory model.
module tb_mem_req_ctrl;

    localparam int unsigned Timeout = 15;

    logic clk;
    logic res;
    logic mem_en;

    mem_req_ctrl_if #(.WIDTH(16), .ADDR_WIDTH(6), .QDEPTH(4)) bus ();

    mem_req_ctrl #(
        .WIDTH(16), .DEPTH(64), .ADDR_WIDTH(6), .QDEPTH(4), .TIMEOUT(Timeout)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    typedef struct packed {
        logic        wr;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    bit [15:0]  mem_arr [64];
    bit [15:0]  ref_mem [64];
    int         n_vec = 0;
    int         n_err = 0;
    logic       prev_mv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1);
    end

    // Memory answers one cycle after sampling mem_valid; mem_en=0 models a dead memory.
    always @(posedge clk) begin
        if (res) begin
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
        end else begin
            bus.mem_ready <= mem_en && bus.mem_valid;
            if (mem_en && bus.mem_valid) begin
                if (bus.mem_wr_rd) mem_arr[bus.mem_addr] <= bus.mem_wdata;
                else               bus.mem_rdata <= mem_arr[bus.mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!res && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_extra", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_wr_rd", 32'(bus.rsp_wr_rd), 32'(mon_e.wr));
                check("rsp_rdata", 32'(bus.rsp_rdata), 32'(mon_e.rdata));
                check("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
            end
        end
    end

    always @(negedge clk) begin
        if (!res && bus.mem_valid) check("mem_valid_single", 32'(prev_mv), 32'd0);
        prev_mv <= bus.mem_valid;
    end

    task automatic push(input logic wr, input logic [5:0] addr, input logic [15:0] data,
                        input logic exp_err, input int limit, output logic ok);
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_wr_rd = wr;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            ok = bus.req_ready;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        if (ok) begin
            e.wr    = wr;
            e.err   = exp_err;
            e.rdata = (wr || exp_err) ? 16'h0 : ref_mem[addr];
            if (wr && !exp_err) ref_mem[addr] = data;
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic wr, input logic [5:0] addr, input logic [15:0] data,
                        input logic exp_err);
        logic ok;
        push(wr, addr, data, exp_err, 200, ok);
        check("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    // From ISSUE cycle to first rsp_valid cycle, plus mem_valid pulse width.
    task automatic measure(output int lat, output int mv_cycles);
        lat = 0;
        mv_cycles = 0;
        for (int i = 0; i < 50 && !bus.mem_valid; i++) @(negedge clk);
        if (bus.mem_valid) mv_cycles = 1;
        for (int i = 0; i < 50 && !bus.rsp_valid; i++) begin
            @(negedge clk);
            lat++;
            if (bus.mem_valid) mv_cycles++;
        end
    endtask

    initial begin
        int   lat;
        int   mv;
        logic ok;
        bus.req_valid = 1'b0;
        bus.req_wr_rd = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        mem_en        = 1'b1;
        prev_mv       = 1'b0;
        res           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        res = 1'b0;

        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst_rsp_wr_rd", 32'(bus.rsp_wr_rd), 32'd0);
        check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("rst_mem_wr_rd", 32'(bus.mem_wr_rd), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_q_count", 32'(bus.q_count), 32'd0);
        @(posedge clk);
        #1;

        // Read of the top address after reset, latency with a ready memory.
        send(1'b0, 6'd63, 16'h0, 1'b0);
        measure(lat, mv);
        check("rd63_latency", 32'(lat), 32'd2);
        check("rd63_mem_valid_width", 32'(mv), 32'd1);
        check("rd63_mem_addr_hold", 32'(bus.mem_addr), 32'd63);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        drain();

        send(1'b1, 6'd5, 16'hA5A5, 1'b0);
        send(1'b0, 6'd5, 16'h0, 1'b0);
        drain();

        // Fill the queue with responses held off.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b1, 6'(10 + i), 16'(16'h1000 + i), 1'b0);
        @(negedge clk);
        check("fill_count_3", 32'(bus.q_count), 32'd3);
        @(posedge clk);
        #1;
        send(1'b1, 6'd14, 16'h1004, 1'b0);
        @(negedge clk);
        check("fill_count_4", 32'(bus.q_count), 32'd4);
        check("fill_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        push(1'b1, 6'd20, 16'hDEAD, 1'b0, 1, ok);
        check("full_push_refused", 32'(ok), 32'd0);
        @(negedge clk);
        check("full_count_hold", 32'(bus.q_count), 32'd4);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        drain();
        for (int i = 0; i < 5; i++) send(1'b0, 6'(10 + i), 16'h0, 1'b0);
        send(1'b0, 6'd20, 16'h0, 1'b0);
        drain();

        // Dead memory: timeout, then normal operation again.
        mem_en = 1'b0;
        bus.rsp_ready = 1'b0;
        send(1'b0, 6'd5, 16'h0, 1'b1);
        measure(lat, mv);
        check("timeout_latency", 32'(lat), 32'(Timeout + 1));
        @(posedge clk);
        #1;
        mem_en = 1'b1;
        bus.rsp_ready = 1'b1;
        drain();
        send(1'b0, 6'd5, 16'h0, 1'b0);
        drain();

        // Reset while waiting on memory with two requests still queued.
        mem_en = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b0, 6'd0, 16'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        res = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_wr_rd = 1'b1;
        bus.req_addr  = 6'd0;
        bus.req_wdata = 16'hBEEF;
        @(posedge clk);
        #1;
        res = 1'b0;
        bus.req_valid = 1'b0;
        mem_en = 1'b1;
        @(negedge clk);
        check("abort_q_count", 32'(bus.q_count), 32'd0);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.mem_valid) lat++;
        end
        check("abort_quiet", 32'(lat), 32'd0);
        @(posedge clk);
        #1;
        send(1'b1, 6'd0, 16'h1234, 1'b0);
        send(1'b0, 6'd0, 16'h0, 1'b0);
        drain();

        // Back-to-back traffic: queue fills and drains, pointers wrap several times.
        for (int i = 0; i < 16; i++) begin
            send(1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), 16'($urandom), 1'b0);
        end
        for (int i = 0; i < 16; i++) send(1'b0, 6'(i), 16'h0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
